hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. Drives write-enable and flush of the IF/ID register, the PC write-enable and the ID/EX bubble insert. Resolves load-use stalls, taken branch/jump squashes, and the multi-cycle MULT/DIV busy window. Sits beside the decode stage; all outputs are consumed in the same cycle by the PC register, IF/ID and ID/EX.

## Interface
- MULDIV_LAT, 8: cycles from MULT/DIV issue until HI/LO valid (2..255)
- CNT_W, 32: width of performance counters (perf option only)

- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_id_rs, i_id_rt  in  5 each  source register fields of instruction in ID
- i_id_uses_rs, i_id_uses_rt  in  1 each  ID instruction reads rs / rt
- i_id_uses_hilo  in  1  ID instruction is MFHI/MFLO/MULT/DIV
- i_ex_memread  in  1  EX instruction is a load
- i_ex_rt  in  5  load destination in EX
- i_ex_redirect  in  1  branch taken or jump resolved in EX
- i_ex_muldiv  in  1  MULT/DIV issuing from EX this cycle
- o_pc_we  out  1  PC register write enable
- o_ifid_we  out  1  IF/ID write enable
- o_ifid_flush  out  1  IF/ID flush (clears PC, invalidates instr)
- o_idex_flush  out  1  insert bubble into ID/EX
- o_hilo_busy  out  1  MULT/DIV in progress
- o_stall_cnt, o_flush_cnt  out  CNT_W each  perf counters (perf option only)

## Operation
- State: RUN, MDWAIT; down-counter md_cnt, 8 bits.
- Load-use hazard: i_ex_memread & i_ex_rt≠0 & ((i_id_uses_rs & rs==ex_rt) | (i_id_uses_rt & rt==ex_rt)).
- HI/LO hazard: (state==MDWAIT | i_ex_muldiv) & i_id_uses_hilo.
- Priority, highest first:
  - i_ex_redirect: pc_we=1, ifid_we=1, ifid_flush=1, idex_flush=1. Suppresses any stall (ID instr squashed).
  - HI/LO hazard: pc_we=0, ifid_we=0, idex_flush=1.
  - Load-use: pc_we=0, ifid_we=0, idex_flush=1.
  - Otherwise: pc_we=1, ifid_we=1, flushes 0.
- FSM: RUN→MDWAIT on i_ex_muldiv, md_cnt←MULDIV_LAT-1. MDWAIT: md_cnt decrements each cycle; at md_cnt==1 and no new i_ex_muldiv, next state RUN. i_ex_muldiv in MDWAIT reloads md_cnt (cannot occur without stall, tolerated).
- o_hilo_busy = (state==MDWAIT).
- i_ex_redirect while MDWAIT: flush applied, MDWAIT continues (issued MULT/DIV completes).
- Register 0 never causes a load-use stall.

## Timing
- All hazard outputs combinational (Mealy) from inputs and registered state; zero-cycle latency into PC/IF/ID/ID-EX.
- Load-use costs exactly 1 bubble (load advances to MEM next cycle, hazard clears).
- MULT/DIV issued at cycle T: o_hilo_busy high T+1..T+MULDIV_LAT-1; dependent MFHI in ID stalled through T+MULDIV_LAT-1, released at T+MULDIV_LAT.
- Reset (async, while i_rst_n=0): state=RUN, md_cnt=0, counters=0; o_pc_we=0, o_ifid_we=0, o_ifid_flush=0, o_idex_flush=0, o_hilo_busy=0. Reset mid-MDWAIT aborts the wait immediately.
- First rising edge after deassertion: normal decode from inputs.

## Configuration
- HAZARD_CTRL_PERF_EN defined: o_stall_cnt increments each cycle ifid_we=0 (outside reset); o_flush_cnt increments each cycle ifid_flush=1; both saturate at all-ones, reset to 0.
- Undefined: counter registers absent, o_stall_cnt/o_flush_cnt tied to 0.

## Structure
- Shared package mips_pkg: REG_ZERO (5'd0), state encoding localparams ST_RUN/ST_MDWAIT, REG_ADDR_W=5.
- One sub-module: hazard_perf_cnt (saturating CNT_W counter, inc + async reset), instantiated twice under HAZARD_CTRL_PERF_EN.

## Test plan
- Reset held, random inputs -> all outputs 0; release, idle inputs -> pc_we=1, ifid_we=1, flushes 0.
- ex_memread=1, ex_rt=5, id_rs=5, uses_rs=1 -> one cycle pc_we=0, ifid_we=0, idex_flush=1; same with ex_rt=0 -> no stall.
- Load-use condition plus i_ex_redirect=1 same cycle -> pc_we=1, ifid_flush=1, idex_flush=1, no stall.
- MULDIV_LAT=4, i_ex_muldiv at T, MFHI held in ID -> stall T..T+3, hilo_busy T+1..T+3, release T+4.
- Async reset pulse at T+2 of MULT/DIV -> hilo_busy drops without clock edge; RUN after release.
- PERF_EN: 3 load-use stalls + 2 redirects -> o_stall_cnt=3, o_flush_cnt=2; CNT_W=4 forced 20 stalls -> 15.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: register-file constants and the hazard
// controller state encoding.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  localparam logic ST_RUN    = 1'b0;
  localparam logic ST_MDWAIT = 1'b1;

  typedef enum logic {
    RUN    = ST_RUN,
    MDWAIT = ST_MDWAIT
  } hz_state_e;

endpackage : mips_pkg

// File: rtl/hazard_ctrl_if.sv
// Decode/execute hazard bundle: the pipeline (master) drives the ID/EX
// observations, the hazard controller (slave) returns the stall/flush controls.
interface hazard_ctrl_if
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) ();

  logic [REG_ADDR_W-1:0] i_id_rs;
  logic [REG_ADDR_W-1:0] i_id_rt;
  logic                  i_id_uses_rs;
  logic                  i_id_uses_rt;
  logic                  i_id_uses_hilo;
  logic                  i_ex_memread;
  logic [REG_ADDR_W-1:0] i_ex_rt;
  logic                  i_ex_redirect;
  logic                  i_ex_muldiv;

  logic                  o_pc_we;
  logic                  o_ifid_we;
  logic                  o_ifid_flush;
  logic                  o_idex_flush;
  logic                  o_hilo_busy;
  logic [CNT_W-1:0]      o_stall_cnt;
  logic [CNT_W-1:0]      o_flush_cnt;

  modport master (
    output i_id_rs, i_id_rt, i_id_uses_rs, i_id_uses_rt, i_id_uses_hilo,
           i_ex_memread, i_ex_rt, i_ex_redirect, i_ex_muldiv,
    input  o_pc_we, o_ifid_we, o_ifid_flush, o_idex_flush, o_hilo_busy,
           o_stall_cnt, o_flush_cnt
  );

  modport slave (
    input  i_id_rs, i_id_rt, i_id_uses_rs, i_id_uses_rt, i_id_uses_hilo,
           i_ex_memread, i_ex_rt, i_ex_redirect, i_ex_muldiv,
    output o_pc_we, o_ifid_we, o_ifid_flush, o_idex_flush, o_hilo_busy,
           o_stall_cnt, o_flush_cnt
  );

endinterface : hazard_ctrl_if

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter used for hazard performance statistics.
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] cnt_r;

  // Count qualifying cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (i_inc && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign o_cnt = cnt_r;

endmodule : hazard_perf_cnt

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, redirect squashes and MULT/DIV
// busy window. Define HAZARD_CTRL_PERF_EN to build the stall/flush counters.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int MULDIV_LAT = 8,
  parameter int CNT_W      = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  hazard_ctrl_if.slave  hz
);

  localparam logic [7:0] MD_RELOAD = 8'(MULDIV_LAT - 1);

  hz_state_e  state_r;
  logic [7:0] md_cnt_r;
  logic       load_use_s;
  logic       hilo_haz_s;
  logic       pc_we_s;
  logic       ifid_we_s;
  logic       ifid_flush_s;
  logic       idex_flush_s;

  // Hazard detection; register 0 is hard-wired so it never creates a dependency.
  always_comb begin
    load_use_s = 1'b0;
    hilo_haz_s = 1'b0;
    if (hz.i_ex_memread && (hz.i_ex_rt != REG_ZERO)) begin
      load_use_s = (hz.i_id_uses_rs && (hz.i_id_rs == hz.i_ex_rt)) ||
                   (hz.i_id_uses_rt && (hz.i_id_rt == hz.i_ex_rt));
    end else begin
      load_use_s = 1'b0;
    end
    hilo_haz_s = ((state_r == MDWAIT) || hz.i_ex_muldiv) && hz.i_id_uses_hilo;
  end

  // Mealy control outputs; a redirect squashes the ID instruction, so it wins over any stall.
  always_comb begin
    pc_we_s      = 1'b0;
    ifid_we_s    = 1'b0;
    ifid_flush_s = 1'b0;
    idex_flush_s = 1'b0;
    if (!i_rst_n) begin
      pc_we_s      = 1'b0;
      ifid_we_s    = 1'b0;
      ifid_flush_s = 1'b0;
      idex_flush_s = 1'b0;
    end else if (hz.i_ex_redirect) begin
      pc_we_s      = 1'b1;
      ifid_we_s    = 1'b1;
      ifid_flush_s = 1'b1;
      idex_flush_s = 1'b1;
    end else if (hilo_haz_s || load_use_s) begin
      idex_flush_s = 1'b1;
    end else begin
      pc_we_s      = 1'b1;
      ifid_we_s    = 1'b1;
    end
  end

  // MULT/DIV busy tracker; a redirect does not cancel an already issued operation.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r  <= RUN;
      md_cnt_r <= 8'd0;
    end else begin
      case (state_r)
        RUN: begin
          if (hz.i_ex_muldiv) begin
            state_r  <= MDWAIT;
            md_cnt_r <= MD_RELOAD;
          end else begin
            state_r  <= RUN;
            md_cnt_r <= md_cnt_r;
          end
        end
        MDWAIT: begin
          if (hz.i_ex_muldiv) begin
            state_r  <= MDWAIT;
            md_cnt_r <= MD_RELOAD;
          end else if (md_cnt_r <= 8'd1) begin
            state_r  <= RUN;
            md_cnt_r <= 8'd0;
          end else begin
            state_r  <= MDWAIT;
            md_cnt_r <= md_cnt_r - 8'd1;
          end
        end
        default: begin
          state_r  <= RUN;
          md_cnt_r <= 8'd0;
        end
      endcase
    end
  end

  assign hz.o_pc_we      = pc_we_s;
  assign hz.o_ifid_we    = ifid_we_s;
  assign hz.o_ifid_flush = ifid_flush_s;
  assign hz.o_idex_flush = idex_flush_s;
  assign hz.o_hilo_busy  = (state_r == MDWAIT);

`ifdef HAZARD_CTRL_PERF_EN
  hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (~ifid_we_s),
    .o_cnt   (hz.o_stall_cnt)
  );

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (ifid_flush_s),
    .o_cnt   (hz.o_flush_cnt)
  );
`else
  assign hz.o_stall_cnt = {CNT_W{1'b0}};
  assign hz.o_flush_cnt = {CNT_W{1'b0}};
`endif

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic
// compared against a cycle-numbered behavioural model.
module tb_hazard_ctrl;

  localparam int LAT   = 4;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  hazard_ctrl #(.MULDIV_LAT(LAT), .CNT_W(CNT_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .hz      (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: absolute cycle number, last cycle of the MULT/DIV busy window, perf counts.
  int cyc      = 0;
  int busy_end = -1;
  int m_stall  = 0;
  int m_flush  = 0;
  logic e_pc, e_ifwe, e_iff, e_idf, e_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    hz.i_id_rs = 5'd0;       hz.i_id_rt = 5'd0;
    hz.i_id_uses_rs = 1'b0;  hz.i_id_uses_rt = 1'b0;
    hz.i_id_uses_hilo = 1'b0;
    hz.i_ex_memread = 1'b0;  hz.i_ex_rt = 5'd0;
    hz.i_ex_redirect = 1'b0; hz.i_ex_muldiv = 1'b0;
  endtask

  task automatic rand_inputs();
    hz.i_id_rs        = 5'($urandom_range(0, 3));
    hz.i_id_rt        = 5'($urandom_range(0, 3));
    hz.i_id_uses_rs   = ($urandom_range(0, 1) == 0);
    hz.i_id_uses_rt   = ($urandom_range(0, 1) == 0);
    hz.i_id_uses_hilo = ($urandom_range(0, 2) == 0);
    hz.i_ex_memread   = ($urandom_range(0, 2) == 0);
    hz.i_ex_rt        = 5'($urandom_range(0, 3));
    hz.i_ex_redirect  = ($urandom_range(0, 7) == 0);
    hz.i_ex_muldiv    = ($urandom_range(0, 9) == 0);
  endtask

  task automatic model_expect();
    bit lu, hh;
    lu = hz.i_ex_memread && (hz.i_ex_rt != 5'd0) &&
         ((hz.i_id_uses_rs && hz.i_id_rs == hz.i_ex_rt) ||
          (hz.i_id_uses_rt && hz.i_id_rt == hz.i_ex_rt));
    hh = ((cyc <= busy_end) || hz.i_ex_muldiv) && hz.i_id_uses_hilo;
    if (!rst_n)                {e_pc, e_ifwe, e_iff, e_idf} = 4'b0000;
    else if (hz.i_ex_redirect) {e_pc, e_ifwe, e_iff, e_idf} = 4'b1111;
    else if (hh || lu)         {e_pc, e_ifwe, e_iff, e_idf} = 4'b0001;
    else                       {e_pc, e_ifwe, e_iff, e_idf} = 4'b1100;
    e_busy = rst_n && (cyc <= busy_end);
  endtask

  task automatic model_reset();
    busy_end = -1;
    m_stall  = 0;
    m_flush  = 0;
  endtask

  function automatic int perf_exp(input int v);
`ifdef HAZARD_CTRL_PERF_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  // Caller sets inputs at the falling edge; check just after, then clock once.
  task automatic step(input string tag);
    #1;
    if (!rst_n) model_reset();
    model_expect();
    chk({tag, ".pc_we"},      32'(hz.o_pc_we),      32'(e_pc));
    chk({tag, ".ifid_we"},    32'(hz.o_ifid_we),    32'(e_ifwe));
    chk({tag, ".ifid_flush"}, 32'(hz.o_ifid_flush), 32'(e_iff));
    chk({tag, ".idex_flush"}, 32'(hz.o_idex_flush), 32'(e_idf));
    chk({tag, ".hilo_busy"},  32'(hz.o_hilo_busy),  32'(e_busy));
    chk({tag, ".stall_cnt"},  32'(hz.o_stall_cnt),  32'(perf_exp(m_stall)));
    chk({tag, ".flush_cnt"},  32'(hz.o_flush_cnt),  32'(perf_exp(m_flush)));
    @(posedge clk);
    if (rst_n) begin
      if (hz.i_ex_muldiv) busy_end = cyc + LAT - 1;
      if (!e_ifwe && m_stall < SAT) m_stall++;
      if (e_iff && m_flush < SAT)   m_flush++;
      cyc++;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    @(negedge clk);

    // Reset held with random inputs: everything quiet.
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      step("rst_hold");
    end
    rst_n = 1'b1;
    idle();
    step("idle");

    // Load-use on rs, then the load has moved on.
    hz.i_ex_memread = 1'b1; hz.i_ex_rt = 5'd5; hz.i_id_rs = 5'd5; hz.i_id_uses_rs = 1'b1;
    step("lu_rs");
    hz.i_ex_memread = 1'b0;
    step("lu_clear");
    // Load to $zero never stalls.
    hz.i_ex_memread = 1'b1; hz.i_ex_rt = 5'd0; hz.i_id_rs = 5'd0;
    step("lu_r0");
    // Load-use on rt with redirect in the same cycle.
    idle();
    hz.i_ex_memread = 1'b1; hz.i_ex_rt = 5'd9; hz.i_id_rt = 5'd9; hz.i_id_uses_rt = 1'b1;
    hz.i_ex_redirect = 1'b1;
    step("lu_redir");
    idle();

    // MULT/DIV at T with dependent MFHI held in ID.
    hz.i_ex_muldiv = 1'b1; hz.i_id_uses_hilo = 1'b1;
    step("md_T");
    hz.i_ex_muldiv = 1'b0;
    for (int i = 1; i <= LAT; i++) step($sformatf("md_T%0d", i));
    chk("md_released", 32'(hz.o_hilo_busy), 32'd0);

    // Redirect in the busy window keeps the wait running.
    hz.i_ex_muldiv = 1'b1;
    step("md2_T");
    hz.i_ex_muldiv = 1'b0; hz.i_ex_redirect = 1'b1;
    step("md2_redir");
    hz.i_ex_redirect = 1'b0;
    step("md2_T2");

    // Async reset in the middle of the busy window.
    #1;
    chk("arst_pre_busy", 32'(hz.o_hilo_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_busy", 32'(hz.o_hilo_busy), 32'd0);
    chk("arst_pc_we", 32'(hz.o_pc_we), 32'd0);
    rst_n = 1'b1;
    step("arst_after");
    idle();

    // Three load-use stalls and two redirects from cleared counters.
    rst_n = 1'b0;
    step("perf_rst");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      hz.i_ex_memread = 1'b1; hz.i_ex_rt = 5'd3; hz.i_id_rs = 5'd3; hz.i_id_uses_rs = 1'b1;
      step("perf_lu");
      idle();
      step("perf_idle");
    end
    for (int i = 0; i < 2; i++) begin
      hz.i_ex_redirect = 1'b1;
      step("perf_redir");
      idle();
    end
    #1;
`ifdef HAZARD_CTRL_PERF_EN
    chk("perf_stall3", 32'(hz.o_stall_cnt), 32'd3);
    chk("perf_flush2", 32'(hz.o_flush_cnt), 32'd2);
`else
    chk("perf_stall_tied", 32'(hz.o_stall_cnt), 32'd0);
    chk("perf_flush_tied", 32'(hz.o_flush_cnt), 32'd0);
`endif
    @(negedge clk);

    // Twenty forced stalls saturate the counter.
    hz.i_ex_memread = 1'b1; hz.i_ex_rt = 5'd7; hz.i_id_rt = 5'd7; hz.i_id_uses_rt = 1'b1;
    for (int i = 0; i < 20; i++) step("sat_lu");
    idle();
    #1;
    chk("sat_stall", 32'(hz.o_stall_cnt), 32'(perf_exp(15)));
    @(negedge clk);

    // Random traffic, with an occasional reset pulse.
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      rand_inputs();
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_hazard_ctrl
